// File: rtl/cmp_search.sv
// cmp_search: binary-search initiator recovering a signed 4-bit operand from a compare interface (optional CMP_ONEHOT_CHECK_EN)
module cmp_search #(
  parameter int CMP_LAT = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       cmp1_i,
  input  logic       cmp2_i,
  input  logic       cmp3_i,
`ifdef CMP_ONEHOT_CHECK_EN
  output logic       cmp_err_o,
`endif
  output logic [3:0] probe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       found_o,
  output logic [3:0] result_o,
  output logic [2:0] steps_o
);
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_e;
  state_e            state_q, state_d;
  logic signed [4:0] lo_q, lo_d, hi_q, hi_d;
  logic        [2:0] wait_q, wait_d, steps_q, steps_d;
  logic        [3:0] probe_q, probe_d, result_q, result_d;
  logic              found_q, found_d;
  logic signed [4:0] mid, lo_up, hi_dn;
  logic signed [5:0] nxt_sum, nxt_mid;
  logic              bad;
`ifdef CMP_ONEHOT_CHECK_EN
  logic              cmp_err_q, cmp_err_d;
  assign bad       = !$onehot({cmp1_i, cmp2_i, cmp3_i});
  assign cmp_err_o = cmp_err_q;
`else
  assign bad = 1'b0;
`endif
  assign mid     = {probe_q[3], probe_q};
  assign lo_up   = mid + 5'sd1;
  assign hi_dn   = mid - 5'sd1;
  assign nxt_sum = cmp1_i ? lo_up + hi_q : lo_q + hi_dn;
  assign nxt_mid = nxt_sum >>> 1;
  assign probe_o  = probe_q;
  assign busy_o   = state_q == PROBE;
  assign done_o   = state_q == DONE;
  assign found_o  = found_q;
  assign result_o = result_q;
  assign steps_o  = steps_q;
  // next-state: launch on start, narrow the interval on each sampled probe, finish on EQ/empty/bad flags
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    wait_d   = wait_q;
    probe_d  = probe_q;
    result_d = result_q;
    found_d  = found_q;
    steps_d  = steps_q;
`ifdef CMP_ONEHOT_CHECK_EN
    cmp_err_d = cmp_err_q;
`endif
    if (state_q == IDLE) begin
      if (start_i) begin
        state_d = PROBE;
        lo_d    = -5'sd8;
        hi_d    = 5'sd7;
        probe_d = 4'hf;
        steps_d = 3'd1;
        found_d = 1'b0;
        wait_d  = 3'(CMP_LAT);
`ifdef CMP_ONEHOT_CHECK_EN
        cmp_err_d = 1'b0;
`endif
      end
    end else if (state_q == PROBE) begin
      if (wait_q != 3'd0) begin
        wait_d = wait_q - 3'd1;
      end else if (bad) begin
        state_d = DONE;
        found_d = 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
        cmp_err_d = 1'b1;
`endif
      end else if (cmp2_i) begin
        state_d  = DONE;
        found_d  = 1'b1;
        result_d = probe_q;
      end else if (cmp1_i || cmp3_i) begin
        lo_d = cmp1_i ? lo_up : lo_q;
        hi_d = cmp1_i ? hi_q : hi_dn;
        if (cmp1_i ? lo_up > hi_q : lo_q > hi_dn) begin
          state_d = DONE;
          found_d = 1'b0;
        end else begin
          probe_d = nxt_mid[3:0];
          steps_d = steps_q + 3'd1;
          wait_d  = 3'(CMP_LAT);
        end
      end else begin
        state_d = DONE;
        found_d = 1'b0;
      end
    end else begin
      state_d = IDLE;
    end
  end
  // state register with asynchronous reset abandoning any search in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      lo_q     <= -5'sd8;
      hi_q     <= 5'sd7;
      wait_q   <= '0;
      probe_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      steps_q  <= '0;
`ifdef CMP_ONEHOT_CHECK_EN
      cmp_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      wait_q   <= wait_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      found_q  <= found_d;
      steps_q  <= steps_d;
`ifdef CMP_ONEHOT_CHECK_EN
      cmp_err_q <= cmp_err_d;
`endif
    end
  end
endmodule
